// File: rtl/mmio_pkg.sv
// Shared constants and the address-decode enum for the MEM-stage data-memory / MMIO controller.
// The optional IRQ_MASK register is only decoded when MMIO_IRQ_EN is defined.
package mmio_pkg;

  localparam logic [11:0] IN_BASE      = 12'h000;
  localparam logic [11:0] OUT_BASE     = 12'h100;
  localparam logic [11:0] STATUS_OFF   = 12'h200;
  localparam logic [11:0] IRQ_MASK_OFF = 12'h204;
  localparam int          IO_SEL_BIT   = 31;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_IN,
    SEL_OUT,
    SEL_STATUS,
    SEL_MASK,
    SEL_BAD
  } sel_e;

endpackage

// File: rtl/mmio_in_sync.sv
// One input channel: two-flop synchroniser for an asynchronous device input plus a
// change-detect pulse comparing the synchronised value against its previous-cycle value.
module mmio_in_sync #(
  parameter int IN_W = 4
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [IN_W-1:0] i_din,
  output logic [IN_W-1:0] o_sync,
  output logic            o_change
);

  logic [IN_W-1:0] r_meta;
  logic [IN_W-1:0] r_sync;
  logic [IN_W-1:0] r_prev;

  // NOTE: non-blocking assignments let every flop sample the pre-edge value of its
  // neighbour, which is what makes this a shift chain instead of a single wire.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= i_din;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync   = r_sync;
  assign o_change = (r_sync != r_prev);

endmodule

// File: rtl/mmio_mem_controller.sv
// MEM-stage controller: addr[31]=0 selects the on-chip data RAM, addr[31]=1 the MMIO block
// (input channels, output registers, STATUS). Define MMIO_IRQ_EN to add IRQ_MASK and the irq output.
module mmio_mem_controller
  import mmio_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int N_IN  = 3,
  parameter int IN_W  = 4,
  parameter int N_OUT = 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  input  logic                   we,
  input  logic                   re,
  output logic [31:0]            rdata,
  output logic                   rvalid,
  output logic                   err,
  input  logic [N_IN*IN_W-1:0]   in_dev,
  output logic [N_OUT*32-1:0]    out_dev
`ifdef MMIO_IRQ_EN
  ,
  output logic                   irq
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]     r_mem [DEPTH];
  logic [31:0]     r_out [N_OUT];
  logic [31:0]     r_rdata;
  logic            r_rvalid;
  logic            r_err;
  logic [N_IN-1:0] r_flags;

  logic [IN_W-1:0] w_sync [N_IN];
  logic [N_IN-1:0] w_change;
  logic [N_IN-1:0] w_flags_next;
  logic [9:0]      w_word_off;
  logic [5:0]      w_idx;
  logic [AW-1:0]   w_ram_idx;
  sel_e            w_sel;
  logic [31:0]     w_rd_val;
  logic            w_status_rd;
  logic            w_unused_addr;

  assign w_word_off    = addr[11:2];
  assign w_idx         = w_word_off[5:0];
  assign w_ram_idx     = addr[AW+1:2];
  assign w_unused_addr = ^addr[1:0];

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    mmio_in_sync #(.IN_W(IN_W)) u_sync (
      .clock    (clock),
      .resetn   (resetn),
      .i_din    (in_dev[i*IN_W +: IN_W]),
      .o_sync   (w_sync[i]),
      .o_change (w_change[i])
    );
  end

  // Anything in I/O space with addr[30:12] != 0 or an unpopulated offset decodes as SEL_BAD.
  always_comb begin
    w_sel = SEL_BAD;
    if (!addr[IO_SEL_BIT]) begin
      w_sel = SEL_RAM;
    end else if (addr[30:12] == '0) begin
      if (w_word_off[9:6] == IN_BASE[11:8] && 32'(w_idx) < N_IN)
        w_sel = SEL_IN;
      else if (w_word_off[9:6] == OUT_BASE[11:8] && 32'(w_idx) < N_OUT)
        w_sel = SEL_OUT;
      else if (w_word_off == STATUS_OFF[11:2])
        w_sel = SEL_STATUS;
`ifdef MMIO_IRQ_EN
      else if (w_word_off == IRQ_MASK_OFF[11:2])
        w_sel = SEL_MASK;
`endif
    end
  end

`ifdef MMIO_IRQ_EN
  logic [N_IN-1:0] r_mask;
  logic            r_irq;
  logic [N_IN-1:0] w_mask_next;

  assign w_mask_next = (we && w_sel == SEL_MASK) ? wdata[N_IN-1:0] : r_mask;
`endif

  // NOTE: w_rd_val gets a default before any branch so no path leaves it unassigned,
  // otherwise this block would infer a latch.
  always_comb begin
    w_rd_val = '0;
    case (w_sel)
      SEL_RAM:    w_rd_val = r_mem[w_ram_idx];
      SEL_IN: begin
        for (int i = 0; i < N_IN; i++)
          if (w_idx == 6'(i)) w_rd_val = 32'(w_sync[i]);
      end
      SEL_OUT: begin
        for (int j = 0; j < N_OUT; j++)
          if (w_idx == 6'(j)) w_rd_val = r_out[j];
      end
      SEL_STATUS: w_rd_val = 32'(r_flags);
`ifdef MMIO_IRQ_EN
      SEL_MASK:   w_rd_val = 32'(r_mask);
`endif
      default:    w_rd_val = '0;
    endcase
  end

  // A change seen in the same cycle as a STATUS read survives the clear.
  assign w_status_rd  = re && (w_sel == SEL_STATUS);
  assign w_flags_next = (w_status_rd ? '0 : r_flags) | w_change;

  // NOTE: the RAM array has no reset; its contents are undefined after power-up and
  // only the write port is gated by resetn.
  always_ff @(posedge clock) begin
    if (resetn && we && w_sel == SEL_RAM)
      r_mem[w_ram_idx] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_flags  <= '0;
      for (int j = 0; j < N_OUT; j++) r_out[j] <= '0;
`ifdef MMIO_IRQ_EN
      r_mask   <= '0;
      r_irq    <= 1'b0;
`endif
    end else begin
      r_rvalid <= re;
      r_err    <= (re || we) && (w_sel == SEL_BAD);
      if (re) r_rdata <= w_rd_val;
      r_flags  <= w_flags_next;
      if (we && w_sel == SEL_OUT) begin
        for (int j = 0; j < N_OUT; j++)
          if (w_idx == 6'(j)) r_out[j] <= wdata;
      end
`ifdef MMIO_IRQ_EN
      r_mask   <= w_mask_next;
      r_irq    <= |(w_flags_next & w_mask_next);
`endif
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    assign out_dev[j*32 +: 32] = r_out[j];
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign err    = r_err;
`ifdef MMIO_IRQ_EN
  assign irq    = r_irq;
`endif

endmodule

// File: tb/tb_mmio_mem_controller.sv
// Self-checking bench for mmio_mem_controller: directed cases then randomized traffic,
// every cycle compared against a history-based reference model (irq checked under MMIO_IRQ_EN).
module tb_mmio_mem_controller;

  localparam int DEPTH = 32;
  localparam int N_IN  = 3;
  localparam int IN_W  = 4;
  localparam int N_OUT = 1;
  localparam int IW    = N_IN * IN_W;

  logic              clock = 1'b0;
  logic              resetn;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              we;
  logic              re;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              err;
  logic [IW-1:0]     in_dev;
  logic [N_OUT*32-1:0] out_dev;
`ifdef MMIO_IRQ_EN
  logic              irq;
`endif

  always #5 clock = ~clock;

  mmio_mem_controller #(.DEPTH(DEPTH), .N_IN(N_IN), .IN_W(IN_W), .N_OUT(N_OUT)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .re      (re),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .err     (err),
    .in_dev  (in_dev),
    .out_dev (out_dev)
`ifdef MMIO_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: state as the software-visible registers, inputs as a sample history.
  logic [31:0]   m_mem [DEPTH];
  logic [31:0]   m_out [N_OUT];
  logic [N_IN-1:0] m_flags, m_mask;
  logic          m_irq, m_rvalid, m_err;
  logic [31:0]   m_rdata;
  logic [IW-1:0] m_hist [$];   // [0]=sampled 3 edges ago, [1]=2 edges ago, [2]=last edge
  logic [IW-1:0] cur_in;

  function automatic logic [31:0] chan(input logic [IW-1:0] v, input int i);
    logic [IN_W-1:0] c;
    c = v[i*IN_W +: IN_W];
    return 32'(c);
  endfunction

  // 0 RAM, 1 input, 2 output, 3 STATUS, 4 IRQ_MASK, 5 unmapped
  function automatic int classify(input logic [31:0] a, output int idx);
    int off;
    off = int'(a & 32'h0000_0FFC);
    idx = 0;
    if (a[31] == 1'b0) begin
      idx = int'((a >> 2) % DEPTH);
      return 0;
    end
    if ((a & 32'h7FFF_F000) != 0) return 5;
    if (off < 4 * N_IN) begin idx = off / 4; return 1; end
    if (off >= 'h100 && off < 'h100 + 4 * N_OUT) begin idx = (off - 'h100) / 4; return 2; end
    if (off == 'h200) return 3;
`ifdef MMIO_IRQ_EN
    if (off == 'h204) return 4;
`endif
    return 5;
  endfunction

  task automatic model_step(input logic rst_n, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d, input logic [IW-1:0] inp);
    int k, idx;
    logic [N_IN-1:0] chg;
    logic [31:0] v;
    if (!rst_n) begin
      m_rdata = '0; m_rvalid = 1'b0; m_err = 1'b0;
      for (int j = 0; j < N_OUT; j++) m_out[j] = '0;
      m_flags = '0; m_mask = '0; m_irq = 1'b0;
      m_hist = {IW'(0), IW'(0), IW'(0)};
      return;
    end
    k = classify(a, idx);
    for (int i = 0; i < N_IN; i++) chg[i] = (chan(m_hist[1], i) != chan(m_hist[0], i));
    m_rvalid = r;
    m_err    = (r || w) && (k == 5);
    if (r) begin
      case (k)
        0: v = m_mem[idx];
        1: v = chan(m_hist[1], idx);
        2: v = m_out[idx];
        3: v = 32'(m_flags);
        4: v = 32'(m_mask);
        default: v = '0;
      endcase
      m_rdata = v;
    end
    if (w) begin
      if (k == 0) m_mem[idx] = d;
      if (k == 2) m_out[idx] = d;
      if (k == 4) m_mask = d[N_IN-1:0];
    end
    m_flags = ((r && k == 3) ? '0 : m_flags) | chg;
    m_irq   = |(m_flags & m_mask);
    void'(m_hist.pop_front());
    m_hist.push_back(inp);
  endtask

  task automatic step(input logic rst_n, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    resetn = rst_n; re = r; we = w; addr = a; wdata = d; in_dev = cur_in;
    model_step(rst_n, r, w, a, d, cur_in);
    @(posedge clock);
    @(negedge clock);
    check("rvalid", 32'(rvalid), 32'(m_rvalid));
    check("err",    32'(err),    32'(m_err));
    check("rdata",  rdata,       m_rdata);
    for (int j = 0; j < N_OUT; j++) check("out_dev", out_dev[j*32 +: 32], m_out[j]);
`ifdef MMIO_IRQ_EN
    check("irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b1, 1'b0, a, '0);
  endtask

  initial begin
    cur_in = '0;
    resetn = 1'b0; re = 1'b0; we = 1'b0; addr = '0; wdata = '0; in_dev = '0;
    @(negedge clock);

    // Reset for two cycles while inputs toggle, with a read request pending.
    cur_in = IW'(12'h5A3);
    step(1'b0, 1'b1, 1'b1, 32'h8000_0100, 32'hFFFF_FFFF);
    cur_in = '0;
    step(1'b0, 1'b1, 1'b0, 32'h0000_0000, '0);
    check("rst_rdata",  rdata, 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_out",    out_dev[31:0], 32'h0);
    idle(4);
    rd(32'h8000_0200);
    check("rst_status", rdata, 32'h0);

    // Fill RAM so every later read has a defined value.
    for (int i = 0; i < DEPTH; i++) wr(32'(i * 4), $urandom);

    wr(32'h0000_0010, 32'hDEADBEEF);
    rd(32'h0000_0010);
    check("ram_rd", rdata, 32'hDEADBEEF);
    check("ram_rvalid", 32'(rvalid), 32'h1);
    rd(32'h0000_0090);
    check("ram_alias", rdata, 32'hDEADBEEF);

    wr(32'h0000_0008, 32'h11);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'h22);
    check("rbw_old", rdata, 32'h11);
    rd(32'h0000_0008);
    check("rbw_new", rdata, 32'h22);

    // Input channel 1 latency and sticky STATUS flag with read-clear.
    cur_in = IW'(12'h0A0);
    idle(3);
    rd(32'h8000_0004);
    check("in_ch1", rdata, 32'h0000_000A);
    rd(32'h8000_0200);
    check("status_set", rdata, 32'h2);
    rd(32'h8000_0200);
    check("status_clr", rdata, 32'h0);

    wr(32'h8000_0100, 32'h1234);
    check("out_wr", out_dev[31:0], 32'h1234);
    wr(32'h8000_0300, 32'hBAD0_BAD0);
    check("bad_wr_err", 32'(err), 32'h1);
    check("bad_wr_keep", out_dev[31:0], 32'h1234);
    rd(32'h8000_0300);
    check("bad_rd_data", rdata, 32'h0);
    check("bad_rd_err", 32'(err), 32'h1);
    rd(32'h8000_0204);
`ifdef MMIO_IRQ_EN
    check("mask_rd", 32'(err), 32'h0);
`else
    check("mask_unmapped", 32'(err), 32'h1);
`endif
    wr(32'h8000_0000, 32'hFFFF_FFFF);
    check("in_wr_noerr", 32'(err), 32'h0);

`ifdef MMIO_IRQ_EN
    rd(32'h8000_0200);
    wr(32'h8000_0204, 32'h1);
    cur_in = cur_in ^ IW'(1);
    idle(4);
    check("irq_set", 32'(irq), 32'h1);
    rd(32'h8000_0200);
    check("irq_clr", 32'(irq), 32'h0);
    cur_in = cur_in ^ IW'(12'h100);
    idle(4);
    check("irq_masked", 32'(irq), 32'h0);
    rd(32'h8000_0200);
`endif

    // Randomized traffic across RAM, every I/O register and unmapped space.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic rst_n;
      case ($urandom_range(0, 7))
        0, 1: a = {1'b0, 31'($urandom)};
        2:    a = 32'h8000_0000 | 32'($urandom_range(0, 3) * 4);
        3:    a = 32'h8000_0100 | 32'($urandom_range(0, 1) * 4);
        4:    a = 32'h8000_0200;
        5:    a = 32'h8000_0204;
        6:    a = 32'h8000_0000 | 32'($urandom_range(0, 32'hFFF));
        default: a = 32'h8000_0000 | $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) cur_in = IW'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      step(rst_n, 1'($urandom), ($urandom_range(0, 2) == 0), a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_mem_controller.md
Name: mmio_mem_controller

Overview:
- Parametrised data-memory/MMIO controller for the pipelined CPU's MEM stage.
- addr[31]=0 selects on-chip data RAM; addr[31]=1 selects memory-mapped I/O.
- I/O space has N_IN synchronised input channels with sticky change flags, N_OUT read-back output registers and a status register.
- All reads are registered with one-cycle latency; unmapped reads return 0.

Parameters:
- DEPTH, 32, data RAM words (power of two, >=2); AW = clog2(DEPTH)
- N_IN, 3, input channels (1..16)
- IN_W, 4, bits per input channel (1..32), zero-extended to 32
- N_OUT, 1, output registers (1..16)

Ports:
- clock  in  1  sole clock, rising edge
- resetn  in  1  synchronous active-low reset
- addr  in  32  byte address; bits [1:0] ignored
- wdata  in  32  store data
- we  in  1  write strobe, one access per cycle
- re  in  1  read strobe
- rdata  out  32  read data, valid when rvalid=1
- rvalid  out  1  pulses one cycle after an accepted re
- err  out  1  pulses one cycle after an access (re or we) to an unmapped I/O address
- in_dev  in  N_IN*IN_W  asynchronous device inputs; channel i = bits [i*IN_W +: IN_W]
- out_dev  out  N_OUT*32  output registers; channel j = bits [j*32 +: 32]

Behaviour:
- Reset (resetn=0 at a rising edge):
  - rdata=0, rvalid=0, err=0, out_dev=0, change flags=0, synchroniser flops=0.
  - RAM contents are not reset.
  - Reset overrides any we/re in the same cycle; a read in flight is dropped (rvalid=0 next cycle).
- Address map (I/O offset = addr[11:0], addr[30:12] must be 0, otherwise unmapped):
  - 0x000+4*i: input channel i, read-only, i<N_IN.
  - 0x100+4*j: output register j, read/write, j<N_OUT.
  - 0x200: STATUS, bits [N_IN-1:0] hold the change flags, upper bits 0; read-clear.
  - Everything else in I/O space is unmapped.
- RAM:
  - Word index = addr[AW+1:2]; higher bits of addr[30:0] are ignored, so addresses alias modulo DEPTH.
  - Write is synchronous on we.
- Reads:
  - re at edge N sets rdata/rvalid at edge N+1.
  - rdata holds its last value while rvalid=0.
  - Unmapped read: rdata=0 with err=1.
- Simultaneous re+we to the same location: read returns the pre-write value (read-before-write) for both RAM and out_dev.
- Writes:
  - I/O write to an output register updates out_dev[j] at that edge.
  - Writes to input channels or STATUS are ignored (no err).
  - Writes to unmapped I/O addresses: no state change, err=1.
- Inputs:
  - Each channel passes through a two-flop synchroniser, giving 2-cycle latency to the readable value.
  - A change flag sets when the synchronised value differs from its previous-cycle value.
- STATUS read-clear:
  - Reading STATUS returns the flags, then clears them at the same edge.
  - A change detected in that same cycle wins: its flag remains set.
- err and rvalid are single-cycle pulses; there is no backpressure.

Optional Feature:
- Macro: MMIO_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit), a registered OR of (change flags & mask).
  - Adds read/write register IRQ_MASK at offset 0x204, reset 0, bits [N_IN-1:0] meaningful.
  - irq drops on the cycle after a STATUS read clears the flags, unless a new change arrives.
- Undefined: no irq port, and 0x204 is unmapped (err on access).

Decomposition:
- Package mmio_pkg holds:
  - offset constants IN_BASE=12'h000, OUT_BASE=12'h100, STATUS_OFF=12'h200, IRQ_MASK_OFF=12'h204;
  - IO_SEL_BIT=31;
  - an address-decode enum {SEL_RAM, SEL_IN, SEL_OUT, SEL_STATUS, SEL_MASK, SEL_BAD}.
- Sub-module mmio_in_sync (per channel): two-flop synchroniser plus change-detect pulse, parameter IN_W.
- The top level generates N_IN instances of mmio_in_sync.

Test Plan:
- Reset with resetn=0 for 2 cycles while in_dev toggles -> rdata=0, rvalid=0, out_dev=0; a subsequent STATUS read returns flags reflecting only post-reset changes.
- Write 0xDEADBEEF to 0x0000_0010, then read it -> rvalid=1 and rdata=0xDEADBEEF one cycle later. With DEPTH=32, a read of 0x0000_0090 also returns 0xDEADBEEF (alias).
- Same-cycle re+we to 0x0000_0008 (old 0x11, new 0x22) -> rdata=0x11; the next read returns 0x22.
- Set in_dev ch1 to 4'hA -> a read of 0x8000_0004 issued 3 cycles later returns 0x0000000A; a STATUS read returns 0x2, and a second read returns 0x0.
- Write 0x1234 to 0x8000_0100 -> out_dev[31:0]=0x1234 after that edge. A write to 0x8000_0300 -> err=1, no state change. A read of 0x8000_0300 -> rdata=0, err=1.
- With MMIO_IRQ_EN: mask=0x1, toggle ch0 -> irq=1; a STATUS read -> irq=0 the next cycle. Toggle ch2 only -> irq stays 0.
